// File: rtl/dma_sram_pkg.sv
// Shared definitions for the DMA-side SRAM burst master: FSM encoding,
// default widths and the response buffer depth.
package dma_sram_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ADDR_WIDTH = 9;
  localparam int DEF_LEN_WIDTH  = 9;
  localparam int RSP_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WR    = 2'd1,
    ST_RD    = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Two-entry response buffer for SRAM read data; the head entry is presented
// combinationally and push/pop may occur in the same cycle at any occupancy.
module sram_rsp_fifo
  import dma_sram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  not_empty,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] mem_q [RSP_FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [RSP_FIFO_DEPTH];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  push_fire, pop_fire;

  // A push into a full buffer is only accepted when the head leaves in the same cycle.
  always_comb begin
    pop_fire  = pop && (cnt_q != 2'd0);
    push_fire = push && ((cnt_q != 2'(RSP_FIFO_DEPTH)) || pop_fire);
    mem_d     = mem_q;
    if (push_fire) begin
      mem_d[wr_ptr_q] = push_data;
    end
    wr_ptr_d = wr_ptr_q ^ push_fire;
    rd_ptr_d = rd_ptr_q ^ pop_fire;
    cnt_d    = cnt_q + 2'(push_fire) - 2'(pop_fire);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign not_empty = (cnt_q != 2'd0);
  assign count     = cnt_q;

endmodule

// File: rtl/sram_burst_master.sv
// Burst initiator for the single-port SRAM: streams write beats straight to the
// macro and issues credit-limited reads whose data lands in a 2-entry buffer.
module sram_burst_master
  import dma_sram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  inst_clk,
  input  logic                  inst_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  cmd_done,
  output logic                  busy,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rdata_valid,
  input  logic                  rdata_ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  sram_cs_n,
  output logic                  sram_wr_n,
  output logic [ADDR_WIDTH-1:0] sram_rw_addr,
  output logic [DATA_WIDTH-1:0] sram_data_in,
  input  logic [DATA_WIDTH-1:0] sram_data_out
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  beats_q, beats_d;
  logic                  inflight_q, inflight_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;

  logic [1:0]            fifo_cnt;
  logic                  fifo_valid;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  rd_pop;
  logic                  credit_ok;
  logic                  wr_fire;
  logic                  rd_issue;
  logic                  last_beat;

  // Credit counts buffered beats plus the one in flight, minus the beat leaving now.
  assign rd_pop    = fifo_valid && rdata_ready;
  assign credit_ok = ({1'b0, fifo_cnt} + {2'b00, inflight_q} - {2'b00, rd_pop}) < 3'd2;
  assign wr_fire   = wdata_valid && (state_q == ST_WR);
  assign rd_issue  = (state_q == ST_RD) && credit_ok;
  assign last_beat = (beats_q == '0);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    beats_d    = beats_q;
    inflight_d = rd_issue;
    done_d     = 1'b0;
    din_d      = din_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          beats_d = cmd_len;
          state_d = cmd_write ? ST_WR : ST_RD;
        end
      end
      ST_WR: begin
        if (wr_fire) begin
          din_d   = wdata;
          addr_d  = addr_q + ADDR_WIDTH'(1);
          beats_d = beats_q - LEN_WIDTH'(1);
          if (last_beat) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_RD: begin
        if (rd_issue) begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          beats_d = beats_q - LEN_WIDTH'(1);
          if (last_beat) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (inflight_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge inst_clk or posedge inst_rst) begin
    if (inst_rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      beats_q    <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      din_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      beats_q    <= beats_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      din_q      <= din_d;
    end
  end

  sram_rsp_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rsp_fifo (
    .clk      (inst_clk),
    .rst      (inst_rst),
    .push     (inflight_q),
    .push_data(sram_data_out),
    .pop      (rd_pop),
    .head_data(fifo_head),
    .not_empty(fifo_valid),
    .count    (fifo_cnt)
  );

  // Write strobes are combinational from the fire so a beat reaches the macro in its own cycle.
  assign sram_cs_n    = ~(wr_fire || rd_issue);
  assign sram_wr_n    = ~wr_fire;
  assign sram_rw_addr = addr_q;
  assign sram_data_in = wr_fire ? wdata : din_q;

  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign wdata_ready = (state_q == ST_WR);
  assign cmd_done    = done_q;
  assign rdata_valid = fifo_valid;
  assign rdata       = fifo_head;

endmodule
